base_hps_gpio_input_capture: RTL
================================

# base_hps_gpio_input_capture

Avalon-MM slave parallel input port: the input-direction counterpart of the HPS GPIO output port. External pins are synchronized, debounced, and edge-detected. Detected edges latch into a write-1-to-clear capture register, and a maskable level interrupt is raised toward the HPS. It sits on the same lightweight HPS-to-FPGA bus as the GPIO output block and uses the same 4-word register window.

## Interface
- WIDTH, 2: number of input pins (1..32).
- EDGE_TYPE, 0: captured edge type. 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 0: number of consecutive stable cycles required before the debounced value changes. 0 = debounce bypassed.

- clk  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address within the register window.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits [WIDTH-1:0] are used.
- in_port  in  WIDTH  asynchronous external pins.
- readdata  out  32  registered read data; upper 32-WIDTH bits are always 0.
- irq  out  1  level interrupt, active high.

## Operation
- Register map:
  - 0 DATA (RO): debounced pin value. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (RW): per-bit interrupt enable.
  - 3 EDGECAP (W1C): captured edges. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- A write occurs on any cycle with chipselect=1 and write_n=0.
- Synchronizer: each bit passes through two flops (sync1, then sync2). Both reset to 0.
- Debounce, when DEBOUNCE_CYCLES=N>0, per bit:
  - Down-counter of width clog2(N+1). stable resets to 0.
  - While sync2 == stable, the counter reloads to N-1.
  - While sync2 != stable: if the counter is 0, stable takes sync2 and the counter reloads to N-1; otherwise the counter decrements.
  - Net effect: a glitch must persist for N consecutive cycles to be accepted. Shorter glitches never reach stable.
- When N=0: stable = sync2, with no counter.
- Edge detect:
  - stable_d is a one-cycle delay of stable.
  - rise = stable & ~stable_d; fall = ~stable & stable_d.
  - The event vector is selected by EDGE_TYPE (rise, fall, or rise|fall).
- EDGECAP bit i update each cycle:
  - set if event[i]=1;
  - else cleared if this is a write to address 3 with writedata[i]=1;
  - else held.
  - If a set and a clear occur in the same cycle, the set wins.
- irq = |(EDGECAP & IRQMASK). It is derived from registers only, so it is glitch-free.
- readdata: registered every cycle as the zero-extended value of the register selected by address, independent of chipselect (reserved reads 0). This gives read latency 1.
- Reset asserted at any time, including mid-debounce or mid-write:
  - sync1, sync2, stable, stable_d, counters, IRQMASK, EDGECAP, readdata all return to 0;
  - irq=0 asynchronously;
  - the in-flight write is lost.
- After reset release, the stable_d and stable registers are both 0, so an input held high produces exactly one rising event, not a spurious one.

## Timing
- Pin sampled high at edge k (sync1 captures it):
  - sync2 goes high at k+1;
  - stable goes high at k+1+N;
  - EDGECAP bit and irq (if masked in) go high at k+2+N;
  - readdata shows the new EDGECAP at k+3+N.
- Register write at edge k:
  - the register holds the new value after k;
  - irq reflects an IRQMASK or EDGECAP change after k;
  - a read of the same register shows the new value at readdata after k+1.
- Read: address presented before edge k → readdata valid after edge k, held until the next edge.
- No wait states; the slave never stalls.

## Test plan
- Reset: assert reset mid-cycle with in_port=2'b11 → readdata, irq, and all registers are 0 immediately. Release reset → with N=0, EDGE_TYPE=0, EDGECAP=2'b11 four cycles later.
- Debounce, N=4:
  - a 3-cycle high pulse on in_port[0] → DATA stays 0 and EDGECAP stays 0;
  - a 4-cycle pulse → DATA[0]=1 at k+5 and EDGECAP[0]=1 at k+6.
- Interrupt path:
  - IRQMASK=2'b10 with a rising edge on bit 0 → EDGECAP=01, irq=0;
  - then write IRQMASK=2'b11 → irq=1 the cycle after the write;
  - then write 32'h1 to address 3 → EDGECAP=0, irq=0.
- W1C collision: a rising-edge event on bit 1 in the same cycle as a write of 32'h2 to address 3 → EDGECAP[1]=1 (set wins). A following write of 32'h2 clears it.
- EDGE_TYPE=2: input pattern 0→1→0 on bit 1 with a clear written between the two edges → EDGECAP[1] sets twice. With EDGE_TYPE=1, only the falling edge sets it.
- Read mux and latency: read address 1 → readdata=0. Write 32'hFFFF_FFFF to address 2, then read address 2 → readdata=32'h0000_0003 (WIDTH=2), one cycle after the address is presented.

Source files
------------

// File: rtl/base_hps_gpio_input_capture_if.sv
// -----------------------------------------------------------------------------
// base_hps_gpio_input_capture_if
// Avalon-MM slave bus bundle for the GPIO input-capture port.
//   address     2   word address within the 4-word register window
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata  32   write data
//   readdata   32   registered read data (latency 1)
// The master modport is the bus side (HPS bridge / testbench); the slave
// modport is the capture block.
// -----------------------------------------------------------------------------
interface base_hps_gpio_input_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/base_hps_gpio_input_capture.sv
// -----------------------------------------------------------------------------
// base_hps_gpio_input_capture
// Parallel input port on the lightweight HPS-to-FPGA bus. Pins are
// synchronized, optionally debounced, edge-detected, and latched into a
// write-1-to-clear capture register that drives a maskable level interrupt.
//   clk      in          system clock
//   reset    in          asynchronous active-high reset
//   in_port  in  WIDTH   asynchronous external pins
//   irq      out         level interrupt, |(EDGECAP & IRQMASK)
//   bus      slave       Avalon-MM register window:
//                        0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (W1C)
// -----------------------------------------------------------------------------
module base_hps_gpio_input_capture #(
    parameter int WIDTH           = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  in_port,
    output logic                              irq,
    base_hps_gpio_input_capture_if.slave      bus
);

    localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] stable_d_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [31:0]      readdata_r;

    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] evt_s;
    logic             wr_s;
    logic [WIDTH-1:0] clr_s;
    logic [31:0]      rd_next_s;
    logic             unused_wdata_s;

    // Only the low WIDTH bits of writedata carry register content.
    assign unused_wdata_s = &{1'b0, bus.writedata};

    // Two-flop synchronizer for the asynchronous pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_s = sync2_r;
        end else begin : g_debounce
            localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0]  RELOAD = CW'(DEBOUNCE_CYCLES - 1);

            logic [WIDTH-1:0] stable_r;
            logic [CW-1:0]    cnt_r [WIDTH];

            // Per-bit debounce: a difference must persist until the counter
            // has run down from N-1 to 0 before stable follows the pin.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable_r <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_r[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2_r[i] == stable_r[i]) begin
                            cnt_r[i] <= RELOAD;
                        end else if (cnt_r[i] == '0) begin
                            stable_r[i] <= sync2_r[i];
                            cnt_r[i]    <= RELOAD;
                        end else begin
                            cnt_r[i] <= cnt_r[i] - CW'(1);
                        end
                    end
                end
            end

            assign stable_s = stable_r;
        end
    endgenerate

    assign rise_s = stable_s & ~stable_d_r;
    assign fall_s = ~stable_s & stable_d_r;

    // Select which transitions count as capture events.
    always_comb begin
        evt_s = rise_s;
        case (EDGE_SEL)
            2'd0:    evt_s = rise_s;
            2'd1:    evt_s = fall_s;
            2'd2:    evt_s = rise_s | fall_s;
            default: evt_s = rise_s;
        endcase
    end

    assign wr_s  = bus.chipselect & ~bus.write_n;
    assign clr_s = (wr_s && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

    // Edge history, interrupt mask and capture register; a new event
    // outranks a same-cycle W1C clear of that bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d_r <= '0;
            irqmask_r  <= '0;
            edgecap_r  <= '0;
        end else begin
            stable_d_r <= stable_s;
            edgecap_r  <= evt_s | (edgecap_r & ~clr_s);
            if (wr_s && (bus.address == 2'd2)) begin
                irqmask_r <= bus.writedata[WIDTH-1:0];
            end else begin
                irqmask_r <= irqmask_r;
            end
        end
    end

    // Read mux, zero-extended; evaluated every cycle regardless of chipselect.
    always_comb begin
        rd_next_s = 32'd0;
        case (bus.address)
            2'd0:    rd_next_s[WIDTH-1:0] = stable_s;
            2'd2:    rd_next_s[WIDTH-1:0] = irqmask_r;
            2'd3:    rd_next_s[WIDTH-1:0] = edgecap_r;
            default: rd_next_s = 32'd0;
        endcase
    end

    // Registered read data gives a fixed one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_next_s;
        end
    end

    assign bus.readdata = readdata_r;
    assign irq          = |(edgecap_r & irqmask_r);

endmodule
